decoder_scanner: RTL and testbench

Parametrised, registered binary-to-one-hot decoder with an auto-scan mode. It is the clocked, N-bit successor of the team's 2-to-4 gate-level decoder.
- DIRECT mode: registers the one-hot decode of a select input.
- SCAN mode: walks the one-hot output through every position, holding each for a programmable number of cycles. Used for row/column strobing (LED/keypad matrices) and round-robin channel select.

---
 rtl/decoder_pkg.sv | 16 +
 rtl/decoder_scanner_if.sv | 31 +++
 rtl/onehot_decoder.sv | 18 +
 rtl/decoder_scanner.sv | 128 ++++++++++++
 tb/tb_decoder_scanner.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/decoder_pkg.sv
// Shared definitions for the decoder_scanner block.
//   state_e     : controller state encoding (IDLE / DIRECT / SCAN)
//   MODE_DIRECT : mode input value selecting direct decode
//   MODE_SCAN   : mode input value selecting auto-scan
package decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_e;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage : decoder_pkg

// File: rtl/decoder_scanner_if.sv
// Control/status bundle of decoder_scanner.
//   master drives : en, mode, sel, start, dwell
//   slave drives  : d (N = 2**SEL_W bits), idx, valid, wrap
interface decoder_scanner_if #(
    parameter int SEL_W   = 2,
    parameter int DWELL_W = 8
);
    localparam int N = 2 ** SEL_W;

    logic               en;
    logic               mode;
    logic [SEL_W-1:0]   sel;
    logic               start;
    logic [DWELL_W-1:0] dwell;

    logic [N-1:0]       d;
    logic [SEL_W-1:0]   idx;
    logic               valid;
    logic               wrap;

    modport master (
        output en, mode, sel, start, dwell,
        input  d, idx, valid, wrap
    );

    modport slave (
        input  en, mode, sel, start, dwell,
        output d, idx, valid, wrap
    );

endinterface : decoder_scanner_if

// File: rtl/onehot_decoder.sv
// Purely combinational binary-to-one-hot decoder.
//   bin_i    : SEL_W-bit binary position
//   onehot_o : 2**SEL_W-bit vector with only bit bin_i set
module onehot_decoder #(
    parameter int SEL_W = 2
) (
    input  logic [SEL_W-1:0]    bin_i,
    output logic [2**SEL_W-1:0] onehot_o
);

    always_comb begin
        // NOTE: assigning a default before the selective write keeps every
        // bit driven on every path, so no latch is inferred.
        onehot_o        = '0;
        onehot_o[bin_i] = 1'b1;
    end

endmodule : onehot_decoder

// File: rtl/decoder_scanner.sv
// Registered binary-to-one-hot decoder with an auto-scan mode.
//   clk : rising-edge clock
//   rst : synchronous active-high reset, wins over en
//   bus : decoder_scanner_if.slave
//         en/mode/sel/start/dwell in; d/idx/valid/wrap out (all registered)
// DIRECT decodes sel with one cycle of latency; SCAN walks the active bit
// through every position, holding each for dwell+1 enabled cycles.
module decoder_scanner
    import decoder_pkg::*;
#(
    parameter int SEL_W      = 2,
    parameter int DWELL_W    = 8,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    decoder_scanner_if.slave   bus
);

    localparam int               N        = 2 ** SEL_W;
    localparam logic [N-1:0]     POL_MASK = ACTIVE_LOW ? {N{1'b1}} : {N{1'b0}};
    localparam logic [SEL_W-1:0] IDX_MAX  = '1;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   idx_q,   idx_d;
    logic [DWELL_W-1:0] cnt_q,   cnt_d;
    logic               valid_q, valid_d;
    logic               wrap_q,  wrap_d;
    logic [N-1:0]       d_q,     d_d;
    logic [N-1:0]       onehot_next;

    // Decoding the next index lets d update on the same edge as idx.
    onehot_decoder #(.SEL_W(SEL_W)) u_onehot (
        .bin_i    (idx_d),
        .onehot_o (onehot_next)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        wrap_d  = wrap_q;   // a pending wrap survives disabled cycles

        if (bus.en) begin
            wrap_d = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    valid_d = 1'b0;
                    if (bus.mode == MODE_DIRECT) begin
                        state_d = ST_DIRECT;
                        idx_d   = bus.sel;
                        valid_d = 1'b1;
                    end else if (bus.start) begin
                        state_d = ST_SCAN;
                        idx_d   = '0;
                        cnt_d   = bus.dwell;
                        valid_d = 1'b1;
                    end
                end

                ST_DIRECT: begin
                    if (bus.mode == MODE_SCAN) begin
                        state_d = ST_IDLE;
                        valid_d = 1'b0;
                    end else begin
                        idx_d   = bus.sel;
                        valid_d = 1'b1;
                    end
                end

                ST_SCAN: begin
                    if (bus.mode == MODE_DIRECT) begin
                        state_d = ST_IDLE;
                        valid_d = 1'b0;
                    end else if (bus.start) begin
                        idx_d = '0;
                        cnt_d = bus.dwell;
                    end else if (cnt_q == '0) begin
                        // Natural SEL_W-bit overflow gives the modulo-N step.
                        idx_d  = idx_q + 1'b1;
                        cnt_d  = bus.dwell;
                        wrap_d = (idx_q == IDX_MAX);
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end

        // Masking by valid and polarity inversion happen before the register
        // so d never glitches and has no input-to-output path.
        d_d = (valid_d ? onehot_next : '0) ^ POL_MASK;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the values from before this edge.
        if (rst) begin
            // NOTE: every register here is control state, so all are reset;
            // there is no storage array that could be left unreset.
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            d_q     <= POL_MASK;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
            d_q     <= d_d;
        end
    end

    assign bus.d     = d_q;
    assign bus.idx   = idx_q;
    assign bus.valid = valid_q;
    assign bus.wrap  = wrap_q;

endmodule : decoder_scanner

// File: tb/tb_decoder_scanner.sv
// Directed self-checking bench for decoder_scanner.
// dut_a: SEL_W=2, active-high.  dut_b: SEL_W=3, ACTIVE_LOW=1.
module tb_decoder_scanner;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    decoder_scanner_if #(.SEL_W(2), .DWELL_W(8)) bus_a ();
    decoder_scanner_if #(.SEL_W(3), .DWELL_W(8)) bus_b ();

    decoder_scanner #(.SEL_W(2), .DWELL_W(8), .ACTIVE_LOW(1'b0)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    decoder_scanner #(.SEL_W(3), .DWELL_W(8), .ACTIVE_LOW(1'b1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] oh(input int pos);
        return 64'd1 << pos;
    endfunction

    initial begin
        checks   = 0;
        failures = 0;

        // ---- 1. reset overrides en/mode/start
        rst         = 1'b1;
        bus_a.en    = 1'b1;  bus_a.mode  = 1'b1;  bus_a.start = 1'b1;
        bus_a.sel   = 2'd0;  bus_a.dwell = 8'd0;
        bus_b.en    = 1'b1;  bus_b.mode  = 1'b1;  bus_b.start = 1'b1;
        bus_b.sel   = 3'd0;  bus_b.dwell = 8'd0;
        tick();
        tick();
        check("rst_d",     bus_a.d,     64'h0);
        check("rst_idx",   bus_a.idx,   64'h0);
        check("rst_valid", bus_a.valid, 64'h0);
        check("rst_wrap",  bus_a.wrap,  64'h0);
        check("rst_b_d",   bus_b.d,     64'hFF);

        // reset with en=0 still clears
        rst = 1'b0;
        bus_a.mode = 1'b0;  bus_a.start = 1'b0;  bus_a.sel = 2'd2;
        bus_b.start = 1'b0;
        tick();
        check("pre_rst_d", bus_a.d, 64'h4);
        rst = 1'b1;  bus_a.en = 1'b0;
        tick();
        check("rst_en0_d",     bus_a.d,     64'h0);
        check("rst_en0_valid", bus_a.valid, 64'h0);
        rst = 1'b0;  bus_a.en = 1'b1;

        // ---- 2. DIRECT decode, one cycle latency
        for (int i = 0; i < 4; i++) begin
            bus_a.sel = 2'(i);
            #1;
            if (i > 0) check("direct_hold", bus_a.d, oh(i - 1));
            tick();
            check("direct_d",     bus_a.d,     oh(i));
            check("direct_idx",   bus_a.idx,   64'(i));
            check("direct_valid", bus_a.valid, 64'h1);
        end
        bus_a.mode = 1'b1;
        tick();
        check("direct_exit_d",     bus_a.d,     64'h0);
        check("direct_exit_valid", bus_a.valid, 64'h0);

        // ---- 3. SCAN, dwell=2: 3 cycles per position, wrap 12 cycles after start
        bus_a.dwell = 8'd2;  bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        check("scan_entry_d",    bus_a.d,     64'h1);
        check("scan_entry_val",  bus_a.valid, 64'h1);
        check("scan_entry_wrap", bus_a.wrap,  64'h0);
        for (int c = 1; c <= 13; c++) begin
            tick();
            check("scan3_idx",  bus_a.idx,  64'((c / 3) % 4));
            check("scan3_d",    bus_a.d,    oh((c / 3) % 4));
            check("scan3_wrap", bus_a.wrap, (c == 12) ? 64'h1 : 64'h0);
        end

        // ---- 4. dwell=0 with a pause at idx=2 (restart picks up new dwell)
        bus_a.dwell = 8'd0;  bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        check("restart0_idx",  bus_a.idx,  64'h0);
        check("restart0_wrap", bus_a.wrap, 64'h0);
        tick();
        check("fast_idx1", bus_a.idx, 64'h1);
        tick();
        check("fast_idx2", bus_a.idx, 64'h2);
        bus_a.en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            check("pause_idx", bus_a.idx, 64'h2);
            check("pause_d",   bus_a.d,   64'h4);
        end
        bus_a.en = 1'b1;
        tick();
        check("fast_idx3", bus_a.idx, 64'h3);
        tick();
        check("fast_wrap_idx", bus_a.idx,  64'h0);
        check("fast_wrap",     bus_a.wrap, 64'h1);
        bus_a.en = 1'b0;
        tick();
        check("wrap_held_en0", bus_a.wrap, 64'h1);
        bus_a.en = 1'b1;
        tick();
        check("fast_idx1b",     bus_a.idx,  64'h1);
        check("fast_wrap_drop", bus_a.wrap, 64'h0);

        // ---- 5. restart at idx=3, then exit to IDLE, then re-entry
        tick();
        tick();
        check("pre_restart_idx", bus_a.idx, 64'h3);
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        check("restart_idx",  bus_a.idx,  64'h0);
        check("restart_d",    bus_a.d,    64'h1);
        check("restart_wrap", bus_a.wrap, 64'h0);
        bus_a.mode = 1'b0;
        tick();
        check("scan_exit_d",     bus_a.d,     64'h0);
        check("scan_exit_valid", bus_a.valid, 64'h0);
        bus_a.mode = 1'b1;  bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        check("reentry_idx",  bus_a.idx,  64'h0);
        check("reentry_wrap", bus_a.wrap, 64'h0);
        check("reentry_d",    bus_a.d,    64'h1);

        // ---- 6. SEL_W=3, ACTIVE_LOW=1 build
        bus_b.mode = 1'b0;  bus_b.sel = 3'd5;
        tick();
        check("b_direct_d",   bus_b.d,     64'hDF);
        check("b_direct_idx", bus_b.idx,   64'h5);
        check("b_direct_val", bus_b.valid, 64'h1);
        bus_b.mode = 1'b1;
        tick();
        check("b_idle_d", bus_b.d, 64'hFF);
        bus_b.dwell = 8'd1;  bus_b.start = 1'b1;
        tick();
        bus_b.start = 1'b0;
        check("b_scan_entry_d", bus_b.d, 64'hFE);
        for (int c = 1; c <= 16; c++) begin
            tick();
            check("b_scan_idx",  bus_b.idx,  64'((c / 2) % 8));
            check("b_scan_d",    bus_b.d,    64'hFF ^ oh((c / 2) % 8));
            check("b_scan_wrap", bus_b.wrap, (c == 16) ? 64'h1 : 64'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_decoder_scanner
